// File: rtl/pmt_sync_monitor.sv
// Checks the sync generator's PMT pulse train and switch-control line: locks onto the
// CPI using the single long PRI as a marker and flags PRI, width, switch and dropout faults.
module pmt_sync_monitor #(
  parameter int PW        = 480,
  parameter int PRI_SHORT = 2401,
  parameter int PRI_LONG  = 3001,
  parameter int PULSES    = 100,
  parameter int LEAD      = 6,
  parameter int TOL       = 2,
  parameter int SW_CHK    = 8
) (
  input  logic        sysclk,
  input  logic        btn_n,
  input  logic        pmt_in,
  input  logic        sw_in,
  input  logic        clr_err,
  output logic        locked,
  output logic        cpi_start,
  output logic [6:0]  pulse_idx,
  output logic [15:0] cpi_count,
  output logic        err_pri,
  output logic        err_pw,
  output logic        err_sw,
  output logic        err_drop
);

  localparam logic [11:0] LONG_LO  = 12'(PRI_LONG - TOL);
  localparam logic [11:0] LONG_HI  = 12'(PRI_LONG + TOL);
  localparam logic [11:0] SHORT_LO = 12'(PRI_SHORT - TOL);
  localparam logic [11:0] SHORT_HI = 12'(PRI_SHORT + TOL);
  localparam logic [11:0] PW_LO    = 12'(PW - TOL);
  localparam logic [11:0] PW_HI    = 12'(PW + TOL);
  localparam logic [11:0] SW_CHK_C = 12'(SW_CHK);
  localparam logic [3:0]  LEAD_LO  = 4'(LEAD - 1);
  localparam logic [3:0]  LEAD_HI  = 4'(LEAD + 1);
  localparam logic [6:0]  LAST_IDX = 7'(PULSES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_TRACK, ST_LOCK} state_t;

  logic        pmt_meta_q, pmt_s_q, pmt_d_q;
  logic        sw_meta_q, sw_s_q;
  logic [11:0] per_cnt_q, per_cnt_d;
  logic [11:0] wid_cnt_q, wid_cnt_d;
  logic [3:0]  swh_cnt_q, swh_cnt_d;
  state_t      state_q;
  logic        locked_q, cpi_start_q;
  logic [6:0]  pulse_idx_q;
  logic [15:0] cpi_count_q;
  logic        err_pri_q, err_pw_q, err_sw_q, err_drop_q;

  logic        rise, fall, in_long, in_short, at_last, per_ok, wid_ok, lead_ok;
  logic [6:0]  idx_next;

  assign rise     = pmt_s_q & ~pmt_d_q;
  assign fall     = ~pmt_s_q & pmt_d_q;
  assign in_long  = (per_cnt_q >= LONG_LO) && (per_cnt_q <= LONG_HI);
  assign in_short = (per_cnt_q >= SHORT_LO) && (per_cnt_q <= SHORT_HI);
  assign at_last  = (pulse_idx_q == LAST_IDX);
  assign per_ok   = at_last ? in_long : in_short;
  assign idx_next = at_last ? 7'd0 : pulse_idx_q + 7'd1;
  assign wid_ok   = (wid_cnt_q >= PW_LO) && (wid_cnt_q <= PW_HI);
  assign lead_ok  = (swh_cnt_q >= LEAD_LO) && (swh_cnt_q <= LEAD_HI);

  // Saturating counters; per_cnt/wid_cnt restart at 1 so they hold exact lengths at the edge.
  assign per_cnt_d = rise ? 12'd1 :
                     (per_cnt_q == 12'hFFF) ? per_cnt_q : per_cnt_q + 12'd1;
  assign wid_cnt_d = rise ? 12'd1 :
                     (pmt_s_q && (wid_cnt_q != 12'hFFF)) ? wid_cnt_q + 12'd1 : wid_cnt_q;
  assign swh_cnt_d = !sw_s_q ? 4'd0 :
                     (swh_cnt_q == 4'hF) ? swh_cnt_q : swh_cnt_q + 4'd1;

  always_ff @(posedge sysclk or negedge btn_n) begin
    if (!btn_n) begin
      pmt_meta_q <= 1'b0;
      pmt_s_q    <= 1'b0;
      pmt_d_q    <= 1'b0;
      sw_meta_q  <= 1'b0;
      sw_s_q     <= 1'b0;
      per_cnt_q  <= 12'd0;
      wid_cnt_q  <= 12'd0;
      swh_cnt_q  <= 4'd0;
    end else begin
      pmt_meta_q <= pmt_in;
      pmt_s_q    <= pmt_meta_q;
      pmt_d_q    <= pmt_s_q;
      sw_meta_q  <= sw_in;
      sw_s_q     <= sw_meta_q;
      per_cnt_q  <= per_cnt_d;
      wid_cnt_q  <= wid_cnt_d;
      swh_cnt_q  <= swh_cnt_d;
    end
  end

  // Error sets are written after the clear so a coincident set wins.
  always_ff @(posedge sysclk or negedge btn_n) begin
    if (!btn_n) begin
      state_q     <= ST_IDLE;
      locked_q    <= 1'b0;
      cpi_start_q <= 1'b0;
      pulse_idx_q <= 7'd0;
      cpi_count_q <= 16'd0;
      err_pri_q   <= 1'b0;
      err_pw_q    <= 1'b0;
      err_sw_q    <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      cpi_start_q <= 1'b0;
      if (clr_err) begin
        err_pri_q  <= 1'b0;
        err_pw_q   <= 1'b0;
        err_sw_q   <= 1'b0;
        err_drop_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (rise) state_q <= ST_SEARCH;
        end
        ST_SEARCH: begin
          if (rise && in_long) begin
            state_q     <= ST_TRACK;
            pulse_idx_q <= 7'd0;
          end
        end
        ST_TRACK, ST_LOCK: begin
          if (rise) begin
            if (per_ok) begin
              pulse_idx_q <= idx_next;
              if (!idx_next[0] && !lead_ok) err_sw_q <= 1'b1;
              if (at_last) begin
                cpi_start_q <= 1'b1;
                cpi_count_q <= cpi_count_q + 16'd1;
                state_q     <= ST_LOCK;
                locked_q    <= 1'b1;
              end
            end else begin
              err_pri_q <= 1'b1;
              locked_q  <= 1'b0;
              if (in_long) begin
                state_q     <= ST_TRACK;
                pulse_idx_q <= 7'd0;
              end else begin
                state_q <= ST_SEARCH;
              end
            end
          end else if (fall && !wid_ok) begin
            err_pw_q <= 1'b1;
            locked_q <= 1'b0;
            state_q  <= ST_SEARCH;
          end else if (per_cnt_q > LONG_HI) begin
            err_drop_q <= 1'b1;
            locked_q   <= 1'b0;
            state_q    <= ST_SEARCH;
          end
          // Switch must be high during even-index pulses, low during odd ones.
          if ((per_cnt_q == SW_CHK_C) && (sw_s_q == pulse_idx_q[0])) err_sw_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign locked    = locked_q;
  assign cpi_start = cpi_start_q;
  assign pulse_idx = pulse_idx_q;
  assign cpi_count = cpi_count_q;
  assign err_pri   = err_pri_q;
  assign err_pw    = err_pw_q;
  assign err_sw    = err_sw_q;
  assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_pmt_sync_monitor.sv
// Bench for pmt_sync_monitor with shortened timing parameters: table of generator pulses with
// expected post-decision outputs, checked through a scoreboard, plus dropout and reset sequences.
module tb_pmt_sync_monitor;
  localparam int PW = 8, PRI_SHORT = 30, PRI_LONG = 40, PULSES = 4;
  localparam int LEAD = 6, TOL = 2, SW_CHK = 8;
  localparam logic [3:0] E_PRI = 4'd1, E_PW = 4'd2, E_SW = 4'd4, E_DROP = 4'd8;

  logic sysclk = 1'b0, btn_n = 1'b0, pmt_in = 1'b0, sw_in = 1'b0, clr_err = 1'b0;
  logic locked, cpi_start, err_pri, err_pw, err_sw, err_drop;
  logic [6:0] pulse_idx;
  logic [15:0] cpi_count;

  pmt_sync_monitor #(
    .PW(PW), .PRI_SHORT(PRI_SHORT), .PRI_LONG(PRI_LONG), .PULSES(PULSES),
    .LEAD(LEAD), .TOL(TOL), .SW_CHK(SW_CHK)
  ) dut (
    .sysclk(sysclk), .btn_n(btn_n), .pmt_in(pmt_in), .sw_in(sw_in), .clr_err(clr_err),
    .locked(locked), .cpi_start(cpi_start), .pulse_idx(pulse_idx), .cpi_count(cpi_count),
    .err_pri(err_pri), .err_pw(err_pw), .err_sw(err_sw), .err_drop(err_drop)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int g; int pri; int pw; int lead; bit sw_bad; bit clr;
    bit e_locked; int e_idx; bit e_cs; int e_cnt; logic [3:0] e_err;
  } vec_t;
  typedef struct {
    int due; int row; bit locked; int idx; bit cs; int cnt; logic [3:0] err;
  } exp_t;

  vec_t vec[$];
  exp_t sb[$];
  int   cs_times[$];
  int   n_chk = 0, n_pass = 0;
  int   last_rise = 0;
  bit   prev_cs = 1'b0;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void add(int g, int pri, int pw, int lead, bit sw_bad, bit clr,
                              bit lk, int idx, bit cs, int cnt, logic [3:0] err);
    vec_t v;
    v.g = g; v.pri = pri; v.pw = pw; v.lead = lead; v.sw_bad = sw_bad; v.clr = clr;
    v.e_locked = lk; v.e_idx = idx; v.e_cs = cs; v.e_cnt = cnt; v.e_err = err;
    vec.push_back(v);
  endfunction

  function automatic void nom(int g, bit clr, bit lk, int idx, bit cs, int cnt, logic [3:0] err);
    add(g, (g == PULSES - 1) ? PRI_LONG : PRI_SHORT, PW, LEAD, 1'b0, clr, lk, idx, cs, cnt, err);
  endfunction

  // Acquisition from SEARCH: j<PULSES still searching (idx unchecked), then one tracked CPI, then lock.
  function automatic void acq(int first_j, int base, logic [3:0] err, bit clr_last);
    for (int j = first_j; j <= 2 * PULSES; j++) begin
      if (j < PULSES)          nom(j % PULSES, 1'b0, 1'b0, -1, 1'b0, base, err);
      else if (j < 2 * PULSES) nom(j % PULSES, 1'b0, 1'b0, j - PULSES, 1'b0, base, err);
      else                     nom(0, clr_last, 1'b1, 0, 1'b1, base + 1, err);
    end
  endfunction

  // One generator period: sync high for pw cycles; switch high through even pulses and
  // rising 'lead' cycles before the end of odd periods.
  task automatic drive_row(int i);
    vec_t r;
    exp_t e;
    r = vec[i];
    for (int c = 0; c < r.pri; c++) begin
      @(negedge sysclk);
      pmt_in  = (c < r.pw);
      sw_in   = ((r.g % 2 == 0) && !r.sw_bad) || ((r.g % 2 == 1) && (c >= r.pri - r.lead));
      clr_err = r.clr && (c == 15);
      if (c == 0) begin
        last_rise = cyc;
        e.due = cyc + 3; e.row = i; e.locked = r.e_locked; e.idx = r.e_idx;
        e.cs = r.e_cs; e.cnt = r.e_cnt; e.err = r.e_err;
        sb.push_back(e);
      end
    end
  endtask

  task automatic run_rows(int lo, int hi);
    for (int i = lo; i < hi; i++) drive_row(i);
  endtask

  task automatic idle_until(int target);
    while (cyc < target) begin
      @(negedge sysclk);
      pmt_in = 1'b0; sw_in = 1'b0; clr_err = 1'b0;
    end
  endtask

  // Sync held low after the last pulse: err_drop lands when per_cnt passes PRI_LONG+TOL.
  task automatic dropout(bit coincide);
    int n0;
    n0 = last_rise;
    idle_until(n0 + 3 + PRI_LONG + TOL);
    check("drop_before", int'(err_drop), 0);
    check("drop_locked_before", int'(locked), 1);
    clr_err = coincide;
    @(negedge sysclk);
    clr_err = 1'b0;
    check("drop_set", int'(err_drop), 1);
    check("drop_unlocked", int'(locked), 0);
    @(negedge sysclk);
    if (coincide) begin
      check("drop_set_beats_clr", int'(err_drop), 1);
    end else begin
      clr_err = 1'b1;
      @(negedge sysclk);
      clr_err = 1'b0;
      @(negedge sysclk);
      check("drop_cleared", int'(err_drop), 0);
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_cpi_start"}, int'(cpi_start), 0);
    check({tag, "_pulse_idx"}, int'(pulse_idx), 0);
    check({tag, "_cpi_count"}, int'(cpi_count), 0);
    check({tag, "_errs"}, int'({err_drop, err_sw, err_pw, err_pri}), 0);
  endtask

  always @(negedge sysclk) begin
    if (btn_n) begin
      if (cpi_start) begin
        check("cpi_start_one_cycle", int'(prev_cs), 0);
        cs_times.push_back(cyc);
      end
      prev_cs = cpi_start;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("row%0d_due", e.row), e.due, cyc);
        check($sformatf("row%0d_locked", e.row), int'(locked), int'(e.locked));
        if (e.idx >= 0) check($sformatf("row%0d_pulse_idx", e.row), int'(pulse_idx), e.idx);
        check($sformatf("row%0d_cpi_start", e.row), int'(cpi_start), int'(e.cs));
        check($sformatf("row%0d_cpi_count", e.row), int'(cpi_count), e.cnt);
        check($sformatf("row%0d_errs", e.row), int'({err_drop, err_sw, err_pw, err_pri}),
              int'(e.err));
      end
    end else begin
      prev_cs = 1'b0;
    end
  end

  initial begin
    int seg_a, seg_b, seg_c, seg_d, n_cs;

    acq(0, 0, 4'd0, 1'b0);                                   // rows 0-8: acquire, lock
    for (int k = 1; k <= 2 * PULSES; k++)                    // rows 9-16: two more CPIs
      nom(k % PULSES, 1'b0, 1'b1, k % PULSES, (k % PULSES) == 0, 1 + k / PULSES, 4'd0);
    add(1, PRI_SHORT + 5, PW, LEAD, 1'b0, 1'b0, 1'b1, 1, 1'b0, 3, 4'd0);  // 17: bad PRI
    acq(2, 3, E_PRI, 1'b1);                                  // 18-24: re-lock, clear
    add(1, PRI_SHORT, PW - 4, LEAD, 1'b0, 1'b0, 1'b1, 1, 1'b0, 4, 4'd0);  // 25: narrow pulse
    acq(2, 4, E_PW, 1'b1);                                   // 26-32
    nom(1, 1'b0, 1'b1, 1, 1'b0, 5, 4'd0);                    // 33
    add(2, PRI_SHORT, PW, LEAD, 1'b1, 1'b0, 1'b1, 2, 1'b0, 5, 4'd0);      // 34: switch low
    nom(3, 1'b0, 1'b1, 3, 1'b0, 5, E_SW);
    nom(0, 1'b1, 1'b1, 0, 1'b1, 6, E_SW);
    add(1, PRI_SHORT, PW, 3, 1'b0, 1'b0, 1'b1, 1, 1'b0, 6, 4'd0);         // 37: lead of 3
    nom(2, 1'b0, 1'b1, 2, 1'b0, 6, E_SW);
    nom(3, 1'b0, 1'b1, 3, 1'b0, 6, E_SW);
    nom(0, 1'b1, 1'b1, 0, 1'b1, 7, E_SW);
    nom(1, 1'b0, 1'b1, 1, 1'b0, 7, 4'd0);                    // 41
    seg_a = vec.size();
    acq(0, 7, 4'd0, 1'b0);
    nom(1, 1'b0, 1'b1, 1, 1'b0, 8, 4'd0);
    seg_b = vec.size();
    acq(0, 8, E_DROP, 1'b0);
    nom(1, 1'b0, 1'b1, 1, 1'b0, 9, E_DROP);
    seg_c = vec.size();
    acq(0, 0, 4'd0, 1'b0);
    seg_d = vec.size();
    n_cs = 0;
    foreach (vec[i]) if (vec[i].e_cs) n_cs++;

    repeat (3) @(negedge sysclk);
    check_all_zero("reset");
    btn_n = 1'b1;
    repeat (5) @(negedge sysclk);

    run_rows(0, seg_a);
    dropout(1'b0);
    run_rows(seg_a, seg_b);
    dropout(1'b1);
    run_rows(seg_b, seg_c);

    // Asynchronous reset while locked mid-CPI.
    @(negedge sysclk);
    check("pre_reset_locked", int'(locked), 1);
    #2 btn_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (3) @(negedge sysclk);
    btn_n = 1'b1;
    repeat (5) @(negedge sysclk);
    run_rows(seg_c, seg_d);
    repeat (6) @(negedge sysclk);

    check("sb_empty", sb.size(), 0);
    check("cpi_start_total", cs_times.size(), n_cs);
    if (cs_times.size() >= 3) begin
      check("cpi_interval_1", cs_times[1] - cs_times[0], (PULSES - 1) * PRI_SHORT + PRI_LONG);
      check("cpi_interval_2", cs_times[2] - cs_times[1], (PULSES - 1) * PRI_SHORT + PRI_LONG);
    end else begin
      check("cpi_interval_samples", cs_times.size(), 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
